// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, PC stepping and branch offset field.
package cpu_pkg;

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        FETCH    = 2'd1,
        HOLD     = 2'd2
    } fetch_state_t;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam int          IMMED_LSB        = 0;
    localparam int          IMMED_MSB        = 15;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: sequential step or PC-relative branch, modulo 2^32.
module pc_next_calc
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [15:0] immed,
    input  logic        pc_sel,
    output logic [31:0] pc_next
);

    logic [31:0] pc_seq;
    logic [31:0] offset;

    // Branch offset counts words relative to the sequential PC.
    assign pc_seq  = pc + PC_STEP;
    assign offset  = {{14{immed[15]}}, immed, 2'b00};
    assign pc_next = pc_sel ? (pc_seq + offset) : pc_seq;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, req/ack fetch from instruction memory,
// and a held instruction register released by the decoder via pc_lden.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          IMEM_AW  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_lden,
    input  logic               pc_sel,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_ack,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        instr,
    output logic               instr_valid,
    output logic [31:0]        pc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_next;
    logic         capture;
    logic         retire;

    pc_next_calc u_pc_next_calc (
        .pc      (pc),
        .immed   (instr[IMMED_MSB:IMMED_LSB]),
        .pc_sel  (pc_sel),
        .pc_next (pc_next)
    );

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        capture     = 1'b0;
        retire      = 1'b0;
        unique case (state_q)
            RST_WAIT: state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (pc_lden) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = RST_WAIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST_WAIT;
            pc      <= RESET_PC & ~32'h3;
            instr   <= '0;
        end else begin
            state_q <= state_d;
            if (capture) instr <= imem_rdata;
            if (retire)  pc    <= pc_next & ~32'h3;
        end
    end

    assign imem_addr = pc[IMEM_AW+1:2];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit with hand-computed expectations.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_lden;
    logic        pc_sel;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        imem_req;
    logic [9:0]  imem_addr;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_lden     (pc_lden),
        .pc_sel      (pc_sel),
        .imem_rdata  (imem_rdata),
        .imem_ack    (imem_ack),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .instr       (instr),
        .instr_valid (instr_valid),
        .pc          (pc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic give_ack(input logic [31:0] word);
        imem_ack = 1'b1; imem_rdata = word;
        tick();
        imem_ack = 1'b0; imem_rdata = 32'h0;
    endtask

    task automatic do_retire(input logic sel);
        pc_lden = 1'b1; pc_sel = sel;
        tick();
        pc_lden = 1'b0; pc_sel = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pc_lden = 1'b0; pc_sel = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        tick(); tick();
        n_cmp++; if (pc !== 32'h0)    begin n_bad++; $display("FAIL rst_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want %h", instr, 32'h0); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b0)    begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        n_cmp++; if (imem_addr !== 10'd0)  begin n_bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        reset = 1'b0;
        // cycle 1 after release: RST_WAIT
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rstwait_req: got %b want 0", imem_req); end
        tick();
        // cycle 2: FETCH, zero-wait ack
        n_cmp++; if (imem_req !== 1'b1)   begin n_bad++; $display("FAIL first_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 10'd0) begin n_bad++; $display("FAIL first_addr: got %h want 0", imem_addr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL first_valid_early: got %b want 0", instr_valid); end
        give_ack(32'h8000_0001);
        // cycle 3: HOLD
        n_cmp++; if (instr !== 32'h8000_0001) begin n_bad++; $display("FAIL first_instr: got %h want %h", instr, 32'h8000_0001); end
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL first_valid: got %b want 1", instr_valid); end
        n_cmp++; if (imem_req !== 1'b0)    begin n_bad++; $display("FAIL hold_req: got %b want 0", imem_req); end
    endtask

    task automatic test_sequential();
        do_retire(1'b0);
        n_cmp++; if (pc !== 32'd4)        begin n_bad++; $display("FAIL seq_pc: got %h want %h", pc, 32'd4); end
        n_cmp++; if (imem_addr !== 10'd1) begin n_bad++; $display("FAIL seq_addr: got %h want 1", imem_addr); end
        n_cmp++; if (imem_req !== 1'b1)   begin n_bad++; $display("FAIL seq_req: got %b want 1", imem_req); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL seq_valid: got %b want 0", instr_valid); end
    endtask

    // Ack delayed 5 cycles; pc_lden/pc_sel pulsed during FETCH must be ignored.
    task automatic test_wait_states();
        for (int i = 0; i < 5; i++) begin
            pc_lden = 1'b1; pc_sel = i[0];
            n_cmp++; if (imem_req !== 1'b1)   begin n_bad++; $display("FAIL wait_req[%0d]: got %b want 1", i, imem_req); end
            n_cmp++; if (imem_addr !== 10'd1) begin n_bad++; $display("FAIL wait_addr[%0d]: got %h want 1", i, imem_addr); end
            n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL wait_valid[%0d]: got %b want 0", i, instr_valid); end
            tick();
            n_cmp++; if (pc !== 32'd4) begin n_bad++; $display("FAIL lden_in_fetch_pc[%0d]: got %h want %h", i, pc, 32'd4); end
        end
        pc_lden = 1'b0; pc_sel = 1'b0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 10'd1) begin n_bad++; $display("FAIL wait_last: req %b addr %h want 1/1", imem_req, imem_addr); end
        give_ack(32'h0000_0003);
        n_cmp++; if (instr !== 32'h0000_0003) begin n_bad++; $display("FAIL wait_instr: got %h want %h", instr, 32'h3); end
        n_cmp++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin n_bad++; $display("FAIL wait_capture: valid %b req %b want 1/0", instr_valid, imem_req); end
        do_retire(1'b0);
        n_cmp++; if (pc !== 32'd8) begin n_bad++; $display("FAIL wait_retire_pc: got %h want %h", pc, 32'd8); end
    endtask

    task automatic test_branches();
        give_ack(32'h1234_FFFE);
        do_retire(1'b1);
        n_cmp++; if (pc !== 32'd4)        begin n_bad++; $display("FAIL br_back_pc: got %h want %h", pc, 32'd4); end
        n_cmp++; if (imem_addr !== 10'd1) begin n_bad++; $display("FAIL br_back_addr: got %h want 1", imem_addr); end
        give_ack(32'h0000_0000);
        do_retire(1'b0);
        n_cmp++; if (pc !== 32'd8) begin n_bad++; $display("FAIL br_setup_pc: got %h want %h", pc, 32'd8); end
        give_ack(32'hABCD_0003);
    endtask

    // Long stall in HOLD with stray acks, then the forward branch is taken.
    task automatic test_stall();
        for (int i = 0; i < 10; i++) begin
            imem_ack = i[0]; imem_rdata = 32'hBAD0_0000 | i; pc_sel = ~i[0];
            tick();
            n_cmp++; if (instr !== 32'hABCD_0003) begin n_bad++; $display("FAIL stall_instr[%0d]: got %h want %h", i, instr, 32'hABCD_0003); end
            n_cmp++; if (pc !== 32'd8)            begin n_bad++; $display("FAIL stall_pc[%0d]: got %h want %h", i, pc, 32'd8); end
            n_cmp++; if (instr_valid !== 1'b1)    begin n_bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, instr_valid); end
        end
        imem_ack = 1'b0; imem_rdata = 32'h0; pc_sel = 1'b0;
        do_retire(1'b1);
        n_cmp++; if (pc !== 32'd24)       begin n_bad++; $display("FAIL br_fwd_pc: got %h want %h", pc, 32'd24); end
        n_cmp++; if (imem_addr !== 10'd6) begin n_bad++; $display("FAIL br_fwd_addr: got %h want 6", imem_addr); end
    endtask

    // Branch to 0xFFFF_FFFC, fetch an all-zero word, then wrap to 0.
    task automatic test_wrap();
        give_ack(32'h0000_FFF8);
        do_retire(1'b1);
        n_cmp++; if (pc !== 32'hFFFF_FFFC)    begin n_bad++; $display("FAIL wrap_setup_pc: got %h want %h", pc, 32'hFFFF_FFFC); end
        n_cmp++; if (imem_addr !== 10'h3FF)   begin n_bad++; $display("FAIL wrap_setup_addr: got %h want 3ff", imem_addr); end
        give_ack(32'h0000_0000);
        tick(); tick(); tick();
        n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h0) begin n_bad++; $display("FAIL zero_instr_hold: valid %b instr %h want 1/0", instr_valid, instr); end
        do_retire(1'b0);
        n_cmp++; if (pc !== 32'h0)        begin n_bad++; $display("FAIL wrap_pc: got %h want %h", pc, 32'h0); end
        n_cmp++; if (imem_addr !== 10'd0) begin n_bad++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        give_ack(32'h0000_0011);
        do_retire(1'b0);
        tick();
        n_cmp++; if (pc !== 32'd4 || imem_req !== 1'b1) begin n_bad++; $display("FAIL midrst_setup: pc %h req %b want 4/1", pc, imem_req); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if (pc !== 32'h0 || imem_req !== 1'b0) begin n_bad++; $display("FAIL midrst_state: pc %h req %b want 0/0", pc, imem_req); end
        give_ack(32'hDEAD_BEEF);  // arrives in RST_WAIT, must be dropped
        n_cmp++; if (instr !== 32'h0)      begin n_bad++; $display("FAIL midrst_drop_instr: got %h want 0", instr); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_drop_valid: got %b want 0", instr_valid); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 10'd0) begin n_bad++; $display("FAIL midrst_refetch: req %b addr %h want 1/0", imem_req, imem_addr); end
        give_ack(32'h8000_0001);
        n_cmp++; if (instr !== 32'h8000_0001 || instr_valid !== 1'b1) begin n_bad++; $display("FAIL midrst_capture: instr %h valid %b", instr, instr_valid); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_branches();
        test_stall();
        test_wrap();
        test_reset_mid_fetch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
